// File: rtl/frame_update_ctrl_pkg.sv
// Shared types and constants for the frame-synchronous display update controller.
package frame_update_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        COMMIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam int unsigned DATA_W = 72;

    // Byte offsets within the packed 72-bit BCD word, MSB first
    localparam int unsigned OFF_HORA   = 64;
    localparam int unsigned OFF_MIN    = 56;
    localparam int unsigned OFF_SEG    = 48;
    localparam int unsigned OFF_DIA    = 40;
    localparam int unsigned OFF_MES    = 32;
    localparam int unsigned OFF_YEAR   = 24;
    localparam int unsigned OFF_HCRONO = 16;
    localparam int unsigned OFF_MCRONO = 8;
    localparam int unsigned OFF_SCRONO = 0;

    localparam int unsigned V_ACTIVE_DEF     = 480;
    localparam int unsigned BLINK_FRAMES_DEF = 30;

    function automatic logic [7:0] bcd_byte(
        input logic [DATA_W-1:0] d,
        input int unsigned       off
    );
        return d[off +: 8];
    endfunction

endpackage

// File: rtl/frame_update_ctrl_vblank.sv
// Start-of-vertical-blanking detector; the line register advances only on
// pixel-rate ticks so the edge is seen once per frame.
module vblank_detect #(
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_rate,
    input  logic [9:0] pixel_y,
    output logic       frame_tick
);

    localparam logic [9:0] V_LINE = 10'(V_ACTIVE);

    logic [9:0] y_q, y_d;
    logic       tick_q, tick_d;

    always_comb begin
        y_d    = y_q;
        tick_d = 1'b0;
        if (pixel_rate) begin
            y_d    = pixel_y;
            tick_d = (pixel_y == V_LINE) && (y_q != V_LINE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            tick_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/frame_update_ctrl.sv
// Tear-free display update: capture on request, commit at vertical blanking.
// Define FRAME_BLINK_EN to build the frame-based blink generator on parpadeo.
module frame_update_ctrl
    import frame_update_ctrl_pkg::*;
#(
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic              reloj_nexys,
    input  logic              reset_total,
    input  logic              pixel_rate,
    input  logic [9:0]        pixel_y,
    input  logic              upd_req,
    input  logic [DATA_W-1:0] dato_in,
    output logic              upd_ack,
    output logic [DATA_W-1:0] dato_out,
    output logic              pendiente,
    output logic              frame_tick,
    output logic              parpadeo
);

    if (BLINK_FRAMES == 0) begin : g_bad_blink
        $error("BLINK_FRAMES must be nonzero");
    end
    if (V_ACTIVE > 1023) begin : g_bad_vactive
        $error("V_ACTIVE must fit in pixel_y");
    end

    vblank_detect #(
        .V_ACTIVE (V_ACTIVE)
    ) u_vblank (
        .clk        (reloj_nexys),
        .rst        (reset_total),
        .pixel_rate (pixel_rate),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick)
    );

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                ack_q, ack_d;
    logic                pend_q, pend_d;

    // A tick seen in IDLE is ignored, so a same-cycle request waits a frame
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        ack_d    = ack_q;
        pend_d   = pend_q;
        unique case (state_q)
            IDLE: begin
                if (upd_req) begin
                    shadow_d = dato_in;
                    pend_d   = 1'b1;
                    state_d  = PEND;
                end
            end
            PEND: begin
                if (frame_tick) begin
                    pend_d  = 1'b0;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                dout_d  = shadow_q;
                state_d = ACK;
            end
            ACK: begin
                ack_d = 1'b1;
                if (!upd_req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge reloj_nexys or posedge reset_total) begin
        if (reset_total) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            dout_q   <= '0;
            ack_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            ack_q    <= ack_d;
            pend_q   <= pend_d;
        end
    end

    assign dato_out  = dout_q;
    assign upd_ack   = ack_q;
    assign pendiente = pend_q;

`ifdef FRAME_BLINK_EN
    localparam int unsigned CNT_W =
        (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (frame_tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge reloj_nexys or posedge reset_total) begin
        if (reset_total) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign parpadeo = blink_q;
`else
    assign parpadeo = 1'b0;
`endif

endmodule

// File: tb/tb_frame_update_ctrl.sv
// Directed bench for frame_update_ctrl: capture, blanking commit, handshake,
// reset recovery and blink period.
module tb_frame_update_ctrl;
    import frame_update_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_rate = 1'b0;
    logic [9:0]  pixel_y = '0;
    logic        upd_req = 1'b0;
    logic [71:0] dato_in = '0;
    logic        upd_ack;
    logic [71:0] dato_out;
    logic        pendiente;
    logic        frame_tick;
    logic        parpadeo;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [71:0] VA = 72'h12_34_56_01_02_16_00_00_00;
    localparam logic [71:0] V9 = 72'h99_99_99_99_99_99_99_99_99;
    localparam logic [71:0] VB = 72'h23_59_58_31_12_99_01_02_03;
    localparam logic [71:0] VC = 72'h07_08_09_10_11_12_13_14_15;
    localparam logic [71:0] VD = 72'h21_43_05_28_02_24_59_58_57;

    always #5 clk = ~clk;

    frame_update_ctrl dut (
        .reloj_nexys (clk),
        .reset_total (rst),
        .pixel_rate  (pixel_rate),
        .pixel_y     (pixel_y),
        .upd_req     (upd_req),
        .dato_in     (dato_in),
        .upd_ack     (upd_ack),
        .dato_out    (dato_out),
        .pendiente   (pendiente),
        .frame_tick  (frame_tick),
        .parpadeo    (parpadeo)
    );

    task automatic chk(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the tick is visible
    task automatic line(input logic [9:0] y);
        pixel_y    = y;
        pixel_rate = 1'b1;
        @(negedge clk);
        pixel_rate = 1'b0;
    endtask

    task automatic frame();
        line(10'd100);
        line(10'd480);
        @(negedge clk);
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (!upd_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_seen", 72'(upd_ack), 72'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, dato_out, 72'd0);
        chk({tag, "_ack"}, 72'(upd_ack), 72'd0);
        chk({tag, "_pend"}, 72'(pendiente), 72'd0);
        chk({tag, "_tick"}, 72'(frame_tick), 72'd0);
        chk({tag, "_blink"}, 72'(parpadeo), 72'd0);
    endtask

    initial begin
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        rst = 1'b0;
        line(10'd100);
        line(10'd100);

        // Mid-frame request, then input changes after capture
        upd_req = 1'b1;
        dato_in = VA;
        @(negedge clk);
        chk("cap_pend", 72'(pendiente), 72'd1);
        chk("cap_dout", dato_out, 72'd0);
        dato_in = V9;
        line(10'd100);
        line(10'd200);
        chk("midframe_dout", dato_out, 72'd0);
        chk("midframe_pend", 72'(pendiente), 72'd1);
        line(10'd479);
        chk("tick_479", 72'(frame_tick), 72'd0);
        line(10'd480);
        chk("tick_480", 72'(frame_tick), 72'd1);
        chk("tick_dout", dato_out, 72'd0);
        @(negedge clk);
        chk("commit_dout", dato_out, 72'd0);
        chk("tick_one_cycle", 72'(frame_tick), 72'd0);
        @(negedge clk);
        chk("commit_val", dato_out, VA);
        chk("commit_ack0", 72'(upd_ack), 72'd0);
        @(negedge clk);
        chk("ack_rise", 72'(upd_ack), 72'd1);
        chk("ack_pend0", 72'(pendiente), 72'd0);
        chk("hora_byte", 72'(bcd_byte(dato_out, OFF_HORA)), 72'h12);
        chk("year_byte", 72'(bcd_byte(dato_out, OFF_YEAR)), 72'h16);

        // Request held across three frames: single commit
        repeat (3) frame();
        chk("hold_dout", dato_out, VA);
        chk("hold_ack", 72'(upd_ack), 72'd1);
        chk("hold_pend", 72'(pendiente), 72'd0);
        line(10'd480);
        chk("no_retick", 72'(frame_tick), 72'd0);
        upd_req = 1'b0;
        @(negedge clk);
        chk("ack_fall", 72'(upd_ack), 72'd0);

        // Request coincident with frame_tick
        line(10'd100);
        line(10'd480);
        chk("coinc_tick", 72'(frame_tick), 72'd1);
        upd_req = 1'b1;
        dato_in = VB;
        @(negedge clk);
        chk("coinc_pend", 72'(pendiente), 72'd1);
        repeat (3) @(negedge clk);
        chk("coinc_nocommit", dato_out, VA);
        chk("coinc_still_pend", 72'(pendiente), 72'd1);
        line(10'd100);
        line(10'd480);
        @(negedge clk);
        @(negedge clk);
        chk("coinc_commit", dato_out, VB);
        wait_ack();
        upd_req = 1'b0;
        @(negedge clk);
        chk("coinc_ack_fall", 72'(upd_ack), 72'd0);

        // Reset while pending, request left high
        upd_req = 1'b1;
        dato_in = VC;
        @(negedge clk);
        chk("pre_rst_pend", 72'(pendiente), 72'd1);
        line(10'd100);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        dato_in = VD;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rerq_pend", 72'(pendiente), 72'd1);
        chk("rerq_dout", dato_out, 72'd0);
        line(10'd100);
        line(10'd480);
        @(negedge clk);
        @(negedge clk);
        chk("rerq_commit", dato_out, VD);
        wait_ack();
        upd_req = 1'b0;
        @(negedge clk);

        // Blink period over 120 frames from a clean counter
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            logic exp_b;
            frame();
`ifdef FRAME_BLINK_EN
            exp_b = ((k / 30) % 2) == 1;
`else
            exp_b = 1'b0;
`endif
            chk($sformatf("blink_f%0d", k), 72'(parpadeo), 72'(exp_b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_update_ctrl.md
FRAME_UPDATE_CTRL -- requirements
Module: frame_update_ctrl

Interface
REQ-001 The block SHALL have parameter V_ACTIVE, default 480, meaning the number of visible lines; the first blanking line is pixel_y == V_ACTIVE.
REQ-002 The block SHALL have parameter BLINK_FRAMES, default 30, meaning the number of frames per blink half-period.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The ports SHALL be as follows:
- reloj_nexys  in  1  system clock, 100 MHz, rising edge.
- reset_total  in  1  asynchronous reset, active-high.
- pixel_rate  in  1  one-cycle pixel-clock enable tick.
- pixel_y  in  10  current line from the sync generator.
- upd_req  in  1  update request from the time-keeping side; four-phase.
- dato_in  in  72  packed BCD bytes. From MSB: hora, min, seg, dia, mes, year, hcrono, mcrono, scrono.
- upd_ack  out  1  four-phase acknowledge.
- dato_out  out  72  display-side registers, same packing as dato_in.
- pendiente  out  1  high while captured data waits for vertical blanking.
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking.
- parpadeo  out  1  blink flag.

Function
REQ-005 frame_tick SHALL pulse for exactly one reloj_nexys cycle when, on a pixel_rate cycle, pixel_y == V_ACTIVE and the line sampled on the previous pixel_rate cycle was not V_ACTIVE.
REQ-006 The line register used for REQ-005 SHALL update only on cycles where pixel_rate is high.
REQ-007 The FSM SHALL have states IDLE, PEND, COMMIT and ACK.
REQ-008 In IDLE with upd_req=1, the block SHALL capture dato_in into the shadow register on that same edge and go to PEND.
REQ-009 In PEND, pendiente SHALL be 1; on frame_tick the FSM SHALL go to COMMIT.
REQ-010 In COMMIT, lasting one cycle, dato_out SHALL load the shadow register and the FSM SHALL go to ACK.
REQ-011 dato_out SHALL change only in COMMIT, so the display never shows a mid-frame update.
REQ-012 In ACK, upd_ack SHALL be 1; when upd_req=0 the FSM SHALL go to IDLE and upd_ack SHALL be 0 from the next cycle.
REQ-013 If upd_req rises in the same cycle as a frame_tick while in IDLE, the block SHALL capture only; the commit SHALL occur at the following frame_tick, never the current one.
REQ-014 dato_in changes after capture SHALL be ignored until the next IDLE capture.
REQ-015 A frame_tick outside PEND SHALL have no effect on the FSM.
REQ-016 Commit latency SHALL be 1 to 2 cycles after the first frame_tick following capture. upd_ack SHALL rise 1 cycle after dato_out updates.
REQ-017 The block SHALL contain no arithmetic on the data; bytes SHALL be passed through bit-exact.

Reset
REQ-018 reset_total=1 SHALL asynchronously force:
- state to IDLE;
- shadow register and dato_out to 72'h0;
- upd_ack, pendiente, frame_tick and parpadeo to 0;
- the line register to 0;
- the blink counter to 0.
REQ-019 A reset during PEND or ACK SHALL discard the pending data. After release, a still-high upd_req SHALL be treated as a new request in IDLE.

Configuration
REQ-020 With macro FRAME_BLINK_EN defined, a frame counter SHALL count frame_ticks from 0 to BLINK_FRAMES-1, wrap to 0, and toggle parpadeo on each wrap, giving a period of 2*BLINK_FRAMES frames.
REQ-021 Without FRAME_BLINK_EN, parpadeo SHALL be tied to 0, no counter logic SHALL exist, and the port SHALL remain present.

Structure
REQ-022 A shared package SHALL hold:
- the state encoding (IDLE=2'd0, PEND=2'd1, COMMIT=2'd2, ACK=2'd3);
- the byte-offset constants for the 72-bit packing;
- the V_ACTIVE and BLINK_FRAMES defaults.
REQ-023 The REQ-005 detector SHALL be a single sub-module named vblank_detect. The FSM, shadow register and blink counter SHALL stay in the top.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Request mid-frame at pixel_y=100 with dato_in=72'h12_34_56_01_02_16_00_00_00 -> pendiente=1; dato_out unchanged until pixel_y reaches 480; then dato_out equals the captured value; upd_ack=1 one cycle later.
- After capture, change dato_in to all 9s before blanking -> committed dato_out still equals the originally captured value.
- Raise upd_req in the same cycle as frame_tick -> no commit on that tick; commit at the next frame_tick.
- Hold upd_req high for 3 frames after upd_ack -> exactly one commit; upd_ack stays 1 until upd_req=0, then falls after 1 cycle.
- Assert reset_total while in PEND -> all outputs 0 immediately; with upd_req still high after release -> new capture and commit at the next blanking.
- With FRAME_BLINK_EN and BLINK_FRAMES=30, run 120 frames -> parpadeo toggles at frames 30, 60, 90 and 120. Without the macro, parpadeo stays 0.
